crossing_scheduler: RTL and testbench

//  Sequences the four level crossings under railway_system_top. Per crossing: 2-of-3 votes IR/vibration/RFID

---
 rtl/crossing_pkg.sv | 42 ++++
 rtl/crossing_fsm.sv | 144 ++++++++++++++
 rtl/crossing_scheduler.sv | 115 +++++++++++
 tb/tb_crossing_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/crossing_pkg.sv
// Shared types and helpers for the level-crossing scheduler: per-crossing state encoding,
// weather codes, the 2-of-3 detection vote and the timer width calculation.
package crossing_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WARN      = 3'd1,
      ST_LOWER_REQ = 3'd2,
      ST_LOWERING  = 3'd3,
      ST_DOWN      = 3'd4,
      ST_CLEAR     = 3'd5,
      ST_RAISE_REQ = 3'd6,
      ST_RAISING   = 3'd7
   } xing_state_e;

   localparam logic [1:0] WX_CLEAR = 2'b00;
   localparam logic [1:0] WX_FOG   = 2'b01;
   localparam logic [1:0] WX_STORM = 2'b10;

   function automatic logic vote2of3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Any non-clear weather (both storm codes included) stretches the warn/clear windows.
   function automatic logic weather_stretch(input logic [1:0] wx);
      logic stretch;
      case (wx)
         WX_CLEAR: stretch = 1'b0;
         WX_FOG:   stretch = 1'b1;
         WX_STORM: stretch = 1'b1;
         default:  stretch = 1'b1;
      endcase
      return stretch;
   endfunction

   function automatic int timer_width(input int warn_c, input int clear_c, input int extra_c);
      int longest;
      longest = ((warn_c > clear_c) ? warn_c : clear_c) + extra_c + 1;
      return $clog2(longest);
   endfunction

endpackage

// File: rtl/crossing_fsm.sv
// One level crossing: train-detect vote, warn/lower/hold/clear/raise sequencing with a
// down-counting timer, motor request towards the shared arbiter, and lamp/barrier decode.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | road open, nothing detected
// WARN       | yellow + bell, counting down before lowering
// LOWER_REQ  | warn done, waiting for the shared motor to lower
// LOWERING   | motor owned, barrier travelling down
// DOWN       | barrier down, train (or emergency) present
// CLEAR      | train gone, hold-off count before raising
// RAISE_REQ  | hold-off done, waiting for the motor to raise
// RAISING    | motor owned, barrier travelling up (reverses on re-detect)
module crossing_fsm
   import crossing_pkg::*;
#(
   parameter int WARN_CYCLES   = 100,
   parameter int CLEAR_CYCLES  = 50,
   parameter int MOTOR_CYCLES  = 20,
   parameter int WEATHER_EXTRA = 50,
   parameter int TW            = 8
) (
   input  logic       clk_50mhz,
   input  logic       rst_n,
   input  logic       ir_i,
   input  logic       vib_i,
   input  logic       rfid_i,
   input  logic       emergency_i,
   input  logic [1:0] weather_i,
   input  logic       grant_i,
   output logic       motor_req_o,
   output logic       is_lower_o,
   output logic       release_o,
   output logic       yellow_o,
   output logic       red_o,
   output logic       alarm_o,
   output logic       barrier_o
);

   localparam logic [TW-1:0] WARN_LD    = TW'(WARN_CYCLES - 1);
   localparam logic [TW-1:0] WARN_LD_WX = TW'(WARN_CYCLES + WEATHER_EXTRA - 1);
   localparam logic [TW-1:0] CLR_LD     = TW'(CLEAR_CYCLES - 1);
   localparam logic [TW-1:0] CLR_LD_WX  = TW'(CLEAR_CYCLES + WEATHER_EXTRA - 1);
   localparam logic [TW-1:0] MOTOR_LD   = TW'(MOTOR_CYCLES - 1);

   xing_state_e   state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          detect;
   logic          det_any;
   logic          tmr_zero;
   logic          stretch;

   assign detect   = vote2of3(ir_i, vib_i, rfid_i);
   assign det_any  = detect | emergency_i;
   assign tmr_zero = (timer_q == '0);
   assign stretch  = weather_stretch(weather_i);

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (emergency_i) begin
               state_d = ST_LOWER_REQ;
            end else if (detect) begin
               state_d = ST_WARN;
               timer_d = stretch ? WARN_LD_WX : WARN_LD;
            end
         end
         ST_WARN: begin
            if (emergency_i || tmr_zero) state_d = ST_LOWER_REQ;
            else                         timer_d = timer_q - TW'(1);
         end
         ST_LOWER_REQ: begin
            if (grant_i) begin
               state_d = ST_LOWERING;
               timer_d = MOTOR_LD;
            end
         end
         ST_LOWERING: begin
            if (tmr_zero) state_d = ST_DOWN;
            else          timer_d = timer_q - TW'(1);
         end
         ST_DOWN: begin
            if (!det_any) begin
               state_d = ST_CLEAR;
               timer_d = stretch ? CLR_LD_WX : CLR_LD;
            end
         end
         ST_CLEAR: begin
            if (det_any)       state_d = ST_DOWN;
            else if (tmr_zero) state_d = ST_RAISE_REQ;
            else               timer_d = timer_q - TW'(1);
         end
         ST_RAISE_REQ: begin
            if (det_any) begin
               state_d = ST_DOWN;
            end else if (grant_i) begin
               state_d = ST_RAISING;
               timer_d = MOTOR_LD;
            end
         end
         ST_RAISING: begin
            // Reversal keeps the motor: no release, straight back to lowering.
            if (det_any) begin
               state_d = ST_LOWERING;
               timer_d = MOTOR_LD;
            end else if (tmr_zero) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
   end

   // A raise request is withdrawn while a train is seen so a late grant cannot be stranded.
   assign motor_req_o = (state_q == ST_LOWER_REQ) || ((state_q == ST_RAISE_REQ) && !det_any);
   assign is_lower_o  = (state_q == ST_LOWER_REQ);
   assign release_o   = tmr_zero && ((state_q == ST_LOWERING) ||
                                     ((state_q == ST_RAISING) && !det_any));

   assign yellow_o  = (state_q == ST_WARN) || (state_q == ST_LOWER_REQ) || (state_q == ST_LOWERING) ||
                      (state_q == ST_RAISE_REQ) || (state_q == ST_RAISING);
   assign alarm_o   = (state_q == ST_WARN) || (state_q == ST_LOWER_REQ) || (state_q == ST_LOWERING);
   assign red_o     = (state_q == ST_LOWER_REQ) || (state_q == ST_LOWERING) || (state_q == ST_DOWN) ||
                      (state_q == ST_CLEAR) || (state_q == ST_RAISE_REQ);
   assign barrier_o = (state_q == ST_DOWN) || (state_q == ST_CLEAR) || (state_q == ST_RAISE_REQ);

endmodule

// File: rtl/crossing_scheduler.sv
// Four-crossing scheduler: one sequencing FSM per crossing plus a round-robin arbiter for the
// single shared barrier motor supply (lower requests take priority over raise requests).
module crossing_scheduler
   import crossing_pkg::*;
#(
   parameter int N_CROSS       = 4,
   parameter int WARN_CYCLES   = 100,
   parameter int CLEAR_CYCLES  = 50,
   parameter int MOTOR_CYCLES  = 20,
   parameter int WEATHER_EXTRA = 50
) (
   input  logic               clk_50mhz,
   input  logic               rst_n,
   input  logic [N_CROSS-1:0] ir_sensor,
   input  logic [N_CROSS-1:0] vib_sensor,
   input  logic [N_CROSS-1:0] rfid_valid,
   input  logic               emergency_global,
   input  logic [1:0]         weather_mode,
   output logic [N_CROSS-1:0] barrier_down,
   output logic [N_CROSS-1:0] red_light,
   output logic [N_CROSS-1:0] yellow_light,
   output logic [N_CROSS-1:0] alarm_sound,
   output logic               motor_busy,
   output logic [1:0]         motor_owner
);

   localparam int TW = timer_width(WARN_CYCLES, CLEAR_CYCLES, WEATHER_EXTRA);

   logic [N_CROSS-1:0] req, lower, rel, grant, cand;
   logic [N_CROSS-1:0] red_st;
   logic               busy_q, busy_d;
   logic [1:0]         owner_q, owner_d;
   logic [1:0]         ptr_q, ptr_d;
   logic               emerg_q;
   logic               motor_free;
   logic               grant_vld;
   logic [1:0]         grant_idx;
   int                 idx;

   for (genvar g = 0; g < N_CROSS; g++) begin : g_xing
      crossing_fsm #(
         .WARN_CYCLES   (WARN_CYCLES),
         .CLEAR_CYCLES  (CLEAR_CYCLES),
         .MOTOR_CYCLES  (MOTOR_CYCLES),
         .WEATHER_EXTRA (WEATHER_EXTRA),
         .TW            (TW)
      ) u_fsm (
         .clk_50mhz   (clk_50mhz),
         .rst_n       (rst_n),
         .ir_i        (ir_sensor[g]),
         .vib_i       (vib_sensor[g]),
         .rfid_i      (rfid_valid[g]),
         .emergency_i (emergency_global),
         .weather_i   (weather_mode),
         .grant_i     (grant[g]),
         .motor_req_o (req[g]),
         .is_lower_o  (lower[g]),
         .release_o   (rel[g]),
         .yellow_o    (yellow_light[g]),
         .red_o       (red_st[g]),
         .alarm_o     (alarm_sound[g]),
         .barrier_o   (barrier_down[g])
      );
   end

   // Motor counts as free in the cycle its owner finishes, so hand-over costs no idle cycle.
   always_comb begin
      grant      = '0;
      grant_vld  = 1'b0;
      grant_idx  = '0;
      idx        = 0;
      motor_free = !busy_q || rel[owner_q];
      cand       = (|(req & lower)) ? (req & lower) : req;
      if (motor_free) begin
         for (int k = 0; k < N_CROSS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_CROSS) idx = idx - N_CROSS;
            if (!grant_vld && cand[idx]) begin
               grant_vld = 1'b1;
               grant_idx = 2'(idx);
            end
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end

   always_comb begin
      busy_d  = grant_vld | (busy_q & !rel[owner_q]);
      owner_d = grant_vld ? grant_idx : owner_q;
      ptr_d   = ptr_q;
      if (grant_vld) begin
         if (int'(grant_idx) + 1 >= N_CROSS) ptr_d = '0;
         else                                ptr_d = grant_idx + 2'd1;
      end
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
         emerg_q <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         emerg_q <= emergency_global;
      end
   end

   assign red_light   = red_st | {N_CROSS{emerg_q}};
   assign motor_busy  = busy_q;
   assign motor_owner = owner_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler with short timers (WARN=10, CLEAR=5, MOTOR=4, EXTRA=6).
module tb_crossing_scheduler;

   logic       clk_50mhz = 1'b0;
   logic       rst_n;
   logic [3:0] ir_sensor, vib_sensor, rfid_valid;
   logic       emergency_global;
   logic [1:0] weather_mode;
   logic [3:0] barrier_down, red_light, yellow_light, alarm_sound;
   logic       motor_busy;
   logic [1:0] motor_owner;

   int n_checks = 0;
   int n_errors = 0;

   crossing_scheduler #(
      .N_CROSS       (4),
      .WARN_CYCLES   (10),
      .CLEAR_CYCLES  (5),
      .MOTOR_CYCLES  (4),
      .WEATHER_EXTRA (6)
   ) dut (
      .clk_50mhz        (clk_50mhz),
      .rst_n            (rst_n),
      .ir_sensor        (ir_sensor),
      .vib_sensor       (vib_sensor),
      .rfid_valid       (rfid_valid),
      .emergency_global (emergency_global),
      .weather_mode     (weather_mode),
      .barrier_down     (barrier_down),
      .red_light        (red_light),
      .yellow_light     (yellow_light),
      .alarm_sound      (alarm_sound),
      .motor_busy       (motor_busy),
      .motor_owner      (motor_owner)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   typedef struct {
      logic [3:0]  ir, vib, rfid;
      logic        emerg;
      logic [1:0]  wx;
      int          wait_c;
      logic [18:0] exp;
   } vec_t;

   vec_t vecs[25];

   // {barrier, red, yellow, alarm, busy, owner}
   function automatic logic [18:0] ex(input logic [3:0] bar, input logic [3:0] red, input logic [3:0] yel,
                                      input logic [3:0] alm, input logic busy, input logic [1:0] own);
      return {bar, red, yel, alm, busy, own};
   endfunction

   function automatic vec_t mk(input logic [3:0] ir, input logic [3:0] vib, input logic [3:0] rfid,
                               input logic [1:0] wx, input int wait_c, input logic [18:0] exp);
      vec_t v;
      v.ir = ir; v.vib = vib; v.rfid = rfid; v.emerg = 1'b0; v.wx = wx;
      v.wait_c = wait_c; v.exp = exp;
      return v;
   endfunction

   function automatic logic [18:0] outs();
      return {barrier_down, red_light, yellow_light, alarm_sound, motor_busy, motor_owner};
   endfunction

   task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got bar=%h red=%h yel=%h alm=%h busy=%b own=%0d, expected bar=%h red=%h yel=%h alm=%h busy=%b own=%0d",
                  name, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1:0],
                  exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_50mhz);
      #1;
   endtask

   task automatic drive(input logic [3:0] ir, input logic [3:0] vib, input logic [3:0] rfid,
                        input logic emerg, input logic [1:0] wx);
      ir_sensor = ir; vib_sensor = vib; rfid_valid = rfid;
      emergency_global = emerg; weather_mode = wx;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      step(1);
   endtask

   initial begin
      logic [3:0]  bar_e;
      logic [1:0]  own_e;
      logic        busy_e;
      int          busy_cnt;
      logic [18:0] z;
      z = '0;

      // single crossing 0, clear weather, 40-cycle detection
      vecs[0]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 1,  ex(4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 2'd0));
      vecs[1]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 9,  ex(4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 2'd0));
      vecs[2]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 1,  ex(4'h0, 4'h1, 4'h1, 4'h1, 1'b0, 2'd0));
      vecs[3]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 1,  ex(4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 2'd0));
      vecs[4]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 3,  ex(4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 2'd0));
      vecs[5]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 1,  ex(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0));
      vecs[6]  = mk(4'h1, 4'h1, 4'h1, 2'b00, 24, ex(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0));
      vecs[7]  = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0));
      vecs[8]  = mk(4'h0, 4'h0, 4'h0, 2'b00, 4,  ex(4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0));
      vecs[9]  = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0));
      vecs[10] = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 2'd0));
      vecs[11] = mk(4'h0, 4'h0, 4'h0, 2'b00, 3,  ex(4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 2'd0));
      vecs[12] = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0));
      // crossing 2, IR stuck low, storm: 16-cycle warn, 11-cycle clear latched at load
      vecs[13] = mk(4'h0, 4'h4, 4'h4, 2'b10, 1,  ex(4'h0, 4'h0, 4'h4, 4'h4, 1'b0, 2'd0));
      vecs[14] = mk(4'h0, 4'h4, 4'h4, 2'b10, 15, ex(4'h0, 4'h0, 4'h4, 4'h4, 1'b0, 2'd0));
      vecs[15] = mk(4'h0, 4'h4, 4'h4, 2'b10, 1,  ex(4'h0, 4'h4, 4'h4, 4'h4, 1'b0, 2'd0));
      vecs[16] = mk(4'h0, 4'h4, 4'h4, 2'b10, 1,  ex(4'h0, 4'h4, 4'h4, 4'h4, 1'b1, 2'd2));
      vecs[17] = mk(4'h0, 4'h4, 4'h4, 2'b10, 4,  ex(4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 2'd2));
      vecs[18] = mk(4'h0, 4'h0, 4'h0, 2'b10, 1,  ex(4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 2'd2));
      vecs[19] = mk(4'h0, 4'h0, 4'h0, 2'b00, 10, ex(4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 2'd2));
      vecs[20] = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h4, 4'h4, 4'h4, 4'h0, 1'b0, 2'd2));
      vecs[21] = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h0, 4'h0, 4'h4, 4'h0, 1'b1, 2'd2));
      vecs[22] = mk(4'h0, 4'h0, 4'h0, 2'b00, 3,  ex(4'h0, 4'h0, 4'h4, 4'h0, 1'b1, 2'd2));
      vecs[23] = mk(4'h0, 4'h0, 4'h0, 2'b00, 1,  ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2));
      vecs[24] = mk(4'h4, 4'h0, 4'h0, 2'b00, 5,  ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd2));

      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      rst_n = 1'b0;
      step(2);
      check("reset_idle", outs(), z);
      rst_n = 1'b1;
      step(1);

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].ir, vecs[i].vib, vecs[i].rfid, vecs[i].emerg, vecs[i].wx);
         step(vecs[i].wait_c);
         check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
      end

      // reset in the middle of LOWERING on crossing 0
      drive(4'h1, 4'h1, 4'h1, 1'b0, 2'b00);
      step(12);
      check("pre_reset_lowering", outs(), ex(4'h0, 4'h1, 4'h1, 4'h1, 1'b1, 2'd0));
      rst_n = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      #1;
      check("reset_async", outs(), z);
      step(1);
      check("reset_held", outs(), z);
      rst_n = 1'b1;
      step(1);
      check("reset_released", outs(), z);

      // crossings 0,1,3 together: motor served 0,1,3 back to back
      drive(4'hB, 4'hB, 4'hB, 1'b0, 2'b00);
      step(11);
      check("multi_lower_req", outs(), ex(4'h0, 4'hB, 4'hB, 4'hB, 1'b0, 2'd0));
      busy_cnt = 0;
      for (int c = 12; c <= 25; c++) begin
         step(1);
         busy_e = (c <= 23);
         own_e  = (c < 16) ? 2'd0 : (c < 20) ? 2'd1 : 2'd3;
         bar_e  = (c < 16) ? 4'h0 : (c < 20) ? 4'h1 : (c < 24) ? 4'h3 : 4'hB;
         if (motor_busy) busy_cnt++;
         check($sformatf("multi_cyc%0d", c), outs(),
               ex(bar_e, 4'hB, 4'hB & ~bar_e, 4'hB & ~bar_e, busy_e, own_e));
      end
      check("multi_busy_count", 19'(busy_cnt), 19'd12);
      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      step(45);
      check("multi_all_idle", outs(), ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3));

      // re-detect on crossing 1 while raising: reverse with the same motor grant
      drive(4'h2, 4'h2, 4'h2, 1'b0, 2'b00);
      step(12);
      check("rev_lowering", outs(), ex(4'h0, 4'h2, 4'h2, 4'h2, 1'b1, 2'd1));
      step(4);
      check("rev_down", outs(), ex(4'h2, 4'h2, 4'h0, 4'h0, 1'b0, 2'd1));
      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      step(7);
      check("rev_raising", outs(), ex(4'h0, 4'h0, 4'h2, 4'h0, 1'b1, 2'd1));
      step(1);
      drive(4'h2, 4'h2, 4'h0, 1'b0, 2'b00);
      step(1);
      check("rev_reversed", outs(), ex(4'h0, 4'h2, 4'h2, 4'h2, 1'b1, 2'd1));
      step(3);
      check("rev_still_lowering", outs(), ex(4'h0, 4'h2, 4'h2, 4'h2, 1'b1, 2'd1));
      step(1);
      check("rev_down_again", outs(), ex(4'h2, 4'h2, 4'h0, 4'h0, 1'b0, 2'd1));
      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      step(30);
      check("rev_idle", outs(), ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd1));

      // global emergency from all-idle, RR pointer back at 0
      do_reset();
      drive(4'h0, 4'h0, 4'h0, 1'b1, 2'b00);
      step(1);
      check("emerg_red", outs(), ex(4'h0, 4'hF, 4'hF, 4'hF, 1'b0, 2'd0));
      for (int c = 2; c <= 19; c++) begin
         step(1);
         busy_e = (c <= 17);
         own_e  = (c >= 14) ? 2'd3 : 2'((c - 2) / 4);
         for (int k = 0; k < 4; k++) bar_e[k] = (c >= 6 + 4 * k);
         check($sformatf("emerg_cyc%0d", c), outs(), ex(bar_e, 4'hF, ~bar_e, ~bar_e, busy_e, own_e));
      end
      drive(4'h0, 4'h0, 4'h0, 1'b0, 2'b00);
      step(1);
      check("emerg_clear", outs(), ex(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3));
      step(5);
      check("emerg_raise_req", outs(), ex(4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 2'd3));
      step(1);
      check("emerg_raise0", outs(), ex(4'hE, 4'hE, 4'hF, 4'h0, 1'b1, 2'd0));
      step(4);
      check("emerg_raise1", outs(), ex(4'hC, 4'hC, 4'hE, 4'h0, 1'b1, 2'd1));
      step(4);
      check("emerg_raise2", outs(), ex(4'h8, 4'h8, 4'hC, 4'h0, 1'b1, 2'd2));
      step(4);
      check("emerg_raise3", outs(), ex(4'h0, 4'h0, 4'h8, 4'h0, 1'b1, 2'd3));
      step(4);
      check("emerg_done", outs(), ex(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
